// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard: default widths, Tuse/Tnew codes
// and the post-ID stage encoding used by the forwarding selects.
package hazard_pkg;

   localparam int unsigned AW_DEF = 5;
   localparam int unsigned TW_DEF = 2;

   // Tuse / Tnew codes
   localparam logic [TW_DEF-1:0] T_BRANCH = 2'd0;
   localparam logic [TW_DEF-1:0] T_ALU    = 2'd1;
   localparam logic [TW_DEF-1:0] T_STORE  = 2'd2;
   localparam logic [TW_DEF-1:0] T_NONE   = 2'd3;
   localparam logic [TW_DEF-1:0] T_LOAD   = 2'd2;

   // Forwarding select / stage encoding
   localparam logic [TW_DEF-1:0] STG_RF = 2'd0;
   localparam logic [TW_DEF-1:0] STG_EX = 2'd1;
   localparam logic [TW_DEF-1:0] STG_MA = 2'd2;
   localparam logic [TW_DEF-1:0] STG_WB = 2'd3;

   // Counter width able to hold the larger busy count plus the start cycle.
   function automatic int unsigned md_cw(input int unsigned mult_cyc,
                                         input int unsigned div_cyc);
      int unsigned mx;
      mx = (mult_cyc > div_cyc) ? mult_cyc : div_cyc;
      return $clog2(mx + 2);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_ctr.sv
// HI/LO busy counter: loads the operation length on a mult/div start and
// counts down to zero; busy while non-zero.
module md_busy_ctr
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10,
   parameter int unsigned CW       = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic div_i,
   output logic busy_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: reload on start (+1 covers the start cycle), else count down.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = div_i ? CW'(DIV_CYC + 1) : CW'(MULT_CYC + 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard for stall and
// forwarding decisions, plus a HI/LO busy interlock for mult/div.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NREG     = 32,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned TW       = TW_DEF,
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid_ID,
   input  logic [AW-1:0] rs_ID,
   input  logic [AW-1:0] rt_ID,
   input  logic [TW-1:0] Tuse_rs,
   input  logic [TW-1:0] Tuse_rt,
   input  logic [AW-1:0] A3_ID,
   input  logic [TW-1:0] Tnew_ID,
   input  logic          md_start_ID,
   input  logic          md_div_ID,
   input  logic          md_access_ID,
   output logic          Stall,
   output logic [TW-1:0] fwd_rs_ID,
   output logic [TW-1:0] fwd_rt_ID,
   output logic          md_busy
);

   localparam int unsigned CW = md_cw(MULT_CYC, DIV_CYC);

   logic          issue;
   logic          pend [NREG];
   logic [TW-1:0] rem  [NREG];
   logic [TW-1:0] age  [NREG];
   logic          rs_stall, rt_stall, md_stall;

   assign issue = valid_ID & ~Stall;

   for (genvar r = 0; r < NREG; r++) begin : g_entry
      if (r == 0) begin : g_zero
         // Register 0 is hard-wired zero and never pending.
         assign pend[r] = 1'b0;
         assign rem[r]  = '0;
         assign age[r]  = '0;
      end else begin : g_reg
         logic          pend_q, pend_d;
         logic [TW-1:0] rem_q, rem_d;
         logic [TW-1:0] age_q, age_d;
         logic          load;

         assign load = issue && (A3_ID == AW'(r));

         // Age the entry each cycle; a new producer overrides aging.
         always_comb begin
            pend_d = pend_q;
            rem_d  = rem_q;
            age_d  = age_q;
            if (load) begin
               pend_d = 1'b1;
               rem_d  = Tnew_ID;
               age_d  = TW'(1);
            end else if (pend_q) begin
               rem_d = (rem_q == '0) ? '0 : rem_q - 1'b1;
               if (age_q == TW'(DEPTH)) begin
                  pend_d = 1'b0;
                  age_d  = '0;
               end else begin
                  age_d = age_q + 1'b1;
               end
            end
         end

         // Entry state with synchronous reset.
         always_ff @(posedge clk) begin
            if (reset) begin
               pend_q <= 1'b0;
               rem_q  <= '0;
               age_q  <= '0;
            end else begin
               pend_q <= pend_d;
               rem_q  <= rem_d;
               age_q  <= age_d;
            end
         end

         assign pend[r] = pend_q;
         assign rem[r]  = rem_q;
         assign age[r]  = age_q;
      end
   end

   md_busy_ctr #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC),
      .CW       (CW)
   ) u_md_busy_ctr (
      .clk     (clk),
      .reset   (reset),
      .start_i (issue & md_start_ID),
      .div_i   (md_div_ID),
      .busy_o  (md_busy)
   );

   // Stall and forwarding decode from the pre-issue scoreboard state.
   always_comb begin
      rs_stall  = pend[rs_ID] && (rs_ID != '0) && (rem[rs_ID] > Tuse_rs);
      rt_stall  = pend[rt_ID] && (rt_ID != '0) && (rem[rt_ID] > Tuse_rt);
      md_stall  = md_access_ID && md_busy;
      Stall     = valid_ID && (rs_stall || rt_stall || md_stall);
      fwd_rs_ID = TW'(STG_RF);
      fwd_rt_ID = TW'(STG_RF);
      if (pend[rs_ID] && (rs_ID != '0) && (rem[rs_ID] == '0)) fwd_rs_ID = age[rs_ID];
      if (pend[rt_ID] && (rt_ID != '0) && (rem[rt_ID] == '0)) fwd_rt_ID = age[rt_ID];
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: per-cycle expectations are queued as each ID-stage
// instruction is driven and popped when the outputs are sampled.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   localparam int unsigned MULT_CYC = 5;
   localparam int unsigned DIV_CYC  = 10;

   logic       clk, reset, valid_ID;
   logic [4:0] rs_ID, rt_ID, A3_ID;
   logic [1:0] Tuse_rs, Tuse_rt, Tnew_ID;
   logic       md_start_ID, md_div_ID, md_access_ID;
   logic       Stall, md_busy;
   logic [1:0] fwd_rs_ID, fwd_rt_ID;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [4:0] rs;
      logic [1:0] tr;
      logic [4:0] rt;
      logic [1:0] tt;
      logic [4:0] a3;
      logic [1:0] tn;
      logic       ms;
      logic       md;
      logic       ma;
   } stim_t;

   typedef struct packed {
      logic       stall;
      logic [1:0] frs;
      logic [1:0] frt;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   hazard_scoreboard #(
      .NREG     (32),
      .AW       (5),
      .DEPTH    (3),
      .TW       (2),
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_ID     (valid_ID),
      .rs_ID        (rs_ID),
      .rt_ID        (rt_ID),
      .Tuse_rs      (Tuse_rs),
      .Tuse_rt      (Tuse_rt),
      .A3_ID        (A3_ID),
      .Tnew_ID      (Tnew_ID),
      .md_start_ID  (md_start_ID),
      .md_div_ID    (md_div_ID),
      .md_access_ID (md_access_ID),
      .Stall        (Stall),
      .fwd_rs_ID    (fwd_rs_ID),
      .fwd_rt_ID    (fwd_rt_ID),
      .md_busy      (md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t op(input logic [4:0] rs, input logic [1:0] tr,
                                input logic [4:0] rt, input logic [1:0] tt,
                                input logic [4:0] a3, input logic [1:0] tn);
      stim_t s;
      s = '0;
      s.v = 1'b1; s.rs = rs; s.tr = tr; s.rt = rt; s.tt = tt; s.a3 = a3; s.tn = tn;
      return s;
   endfunction

   // mult/div start (ms=1) or mfhi/mflo-style access (ms=0); sources 4/5 are never written.
   function automatic stim_t mdop(input logic ms, input logic md, input logic [4:0] a3);
      stim_t s;
      s = op(5'd4, T_ALU, 5'd5, T_ALU, a3, T_ALU);
      s.ms = ms; s.md = md; s.ma = 1'b1;
      return s;
   endfunction

   function automatic exp_t ex(input logic st, input logic [1:0] fr, input logic [1:0] ft,
                               input logic b);
      exp_t e;
      e.stall = st; e.frs = fr; e.frt = ft; e.busy = b;
      return e;
   endfunction

   task automatic apply(input stim_t s);
      reset        = s.rst;
      valid_ID     = s.v;
      rs_ID        = s.rs;
      Tuse_rs      = s.tr;
      rt_ID        = s.rt;
      Tuse_rt      = s.tt;
      A3_ID        = s.a3;
      Tnew_ID      = s.tn;
      md_start_ID  = s.ms;
      md_div_ID    = s.md;
      md_access_ID = s.ma;
   endtask

   // Bubbles to let every pending entry retire.
   task automatic idle(input int n);
      apply('0);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      apply('0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      st.push_back(op(5'd8, T_BRANCH, 5'd9, T_BRANCH, 5'd0, T_ALU)); xp.push_back(ex(0, 0, 0, 0));
      st.push_back(mdop(1'b0, 1'b0, 5'd0));                         xp.push_back(ex(0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL reset[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy, e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Generic hazard sequence: each task below builds its own table and checks inline.
   task automatic test_load_use();
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      st.push_back(op(5'd0, T_NONE, 5'd0, T_NONE, 5'd8, T_LOAD)); xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd8, T_ALU, 5'd8, T_ALU, 5'd9, T_ALU));    xp.push_back(ex(1, 0, 0, 0));
      // rem=1 now: no stall, and the later-stage muxes own this forward
      st.push_back(op(5'd8, T_ALU, 5'd8, T_ALU, 5'd9, T_ALU));    xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd8, T_BRANCH, 5'd0, T_NONE, 5'd0, T_ALU)); xp.push_back(ex(0, 3, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL load_use[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy, e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
      idle(4);
   endtask

   task automatic test_branch(input bit from_load);
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      st.push_back(op(5'd0, T_NONE, 5'd0, T_NONE, 5'd10, from_load ? T_LOAD : T_ALU));
      xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd10, T_BRANCH, 5'd0, T_BRANCH, 5'd0, T_ALU)); xp.push_back(ex(1, 0, 0, 0));
      if (from_load) begin
         st.push_back(op(5'd10, T_BRANCH, 5'd0, T_BRANCH, 5'd0, T_ALU)); xp.push_back(ex(1, 0, 0, 0));
         st.push_back(op(5'd10, T_BRANCH, 5'd0, T_BRANCH, 5'd0, T_ALU)); xp.push_back(ex(0, 3, 0, 0));
      end else begin
         st.push_back(op(5'd10, T_BRANCH, 5'd0, T_BRANCH, 5'd0, T_ALU)); xp.push_back(ex(0, 2, 0, 0));
      end
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL branch_%s[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     from_load ? "load" : "alu", i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy,
                     e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
      idle(4);
   endtask

   task automatic test_load_store();
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      st.push_back(op(5'd0, T_NONE, 5'd0, T_NONE, 5'd8, T_LOAD)); xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd0, T_ALU, 5'd8, T_STORE, 5'd0, T_ALU));  xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd0, T_ALU, 5'd8, T_STORE, 5'd0, T_ALU));  xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd0, T_ALU, 5'd8, T_STORE, 5'd0, T_ALU));  xp.push_back(ex(0, 0, 3, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL load_store[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy, e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
      idle(4);
   endtask

   task automatic test_zero_reg();
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      st.push_back(op(5'd0, T_ALU, 5'd0, T_NONE, 5'd0, T_ALU));       xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd0, T_BRANCH, 5'd0, T_BRANCH, 5'd0, T_ALU));  xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd0, T_BRANCH, 5'd0, T_BRANCH, 5'd0, T_ALU));  xp.push_back(ex(0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL zero_reg[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy, e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
      idle(4);
   endtask

   // mult/div followed directly by mflo: stalls for CYC+1 cycles.
   task automatic test_md(input bit is_div);
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      int    n;
      n = is_div ? DIV_CYC : MULT_CYC;
      st.push_back(mdop(1'b1, is_div, 5'd0)); xp.push_back(ex(0, 0, 0, 0));
      for (int k = 0; k <= n; k++) begin
         st.push_back(mdop(1'b0, 1'b0, 5'd12)); xp.push_back(ex(1, 0, 0, 1));
      end
      st.push_back(mdop(1'b0, 1'b0, 5'd12)); xp.push_back(ex(0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL md_%s[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     is_div ? "div" : "mult", i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy,
                     e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
      idle(4);
   endtask

   // Non-HI/LO work proceeds under a busy unit; the later mflo waits out the rest.
   task automatic test_md_independent();
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      st.push_back(mdop(1'b1, 1'b0, 5'd0));                         xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd0, T_ALU, 5'd0, T_ALU, 5'd13, T_ALU));     xp.push_back(ex(0, 0, 0, 1));
      for (int k = 0; k < MULT_CYC; k++) begin
         st.push_back(mdop(1'b0, 1'b0, 5'd12)); xp.push_back(ex(1, 0, 0, 1));
      end
      st.push_back(mdop(1'b0, 1'b0, 5'd12)); xp.push_back(ex(0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL md_indep[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy, e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
      idle(4);
   endtask

   // ALU then load to the same register: the newer load entry must win.
   task automatic test_back_to_back();
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      st.push_back(op(5'd0, T_NONE, 5'd0, T_NONE, 5'd11, T_ALU));    xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd11, T_ALU, 5'd0, T_NONE, 5'd11, T_LOAD));   xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd11, T_BRANCH, 5'd0, T_NONE, 5'd0, T_ALU));  xp.push_back(ex(1, 0, 0, 0));
      st.push_back(op(5'd11, T_BRANCH, 5'd0, T_NONE, 5'd0, T_ALU));  xp.push_back(ex(1, 0, 0, 0));
      st.push_back(op(5'd11, T_BRANCH, 5'd0, T_NONE, 5'd0, T_ALU));  xp.push_back(ex(0, 3, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy, e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
      idle(4);
   endtask

   task automatic test_reset_mid();
      stim_t st[$];
      exp_t  xp[$];
      exp_t  e;
      stim_t r;
      r = '0;
      r.rst = 1'b1;
      st.push_back(mdop(1'b1, 1'b0, 5'd0));                         xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd0, T_NONE, 5'd0, T_NONE, 5'd8, T_LOAD));   xp.push_back(ex(0, 0, 0, 1));
      st.push_back(r);                                              xp.push_back(ex(0, 0, 0, 1));
      st.push_back(op(5'd8, T_ALU, 5'd8, T_ALU, 5'd0, T_ALU));      xp.push_back(ex(0, 0, 0, 0));
      st.push_back(op(5'd8, T_BRANCH, 5'd8, T_BRANCH, 5'd0, T_ALU)); xp.push_back(ex(0, 0, 0, 0));
      st.push_back(mdop(1'b0, 1'b0, 5'd0));                         xp.push_back(ex(0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         apply(st[i]);
         sb.push_back(xp[i]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({Stall, fwd_rs_ID, fwd_rt_ID, md_busy} !== e) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
                     i, Stall, fwd_rs_ID, fwd_rt_ID, md_busy, e.stall, e.frs, e.frt, e.busy);
         end
         @(posedge clk);
         #1;
      end
      idle(4);
   endtask

   initial begin
      apply('0);
      reset = 1'b1;
      test_reset();
      test_load_use();
      test_branch(1'b0);
      test_branch(1'b1);
      test_load_store();
      test_zero_reg();
      test_md(1'b0);
      test_md(1'b1);
      test_md_independent();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
